// File: rtl/ibex_rvfi_trace_buf.sv
// ibex_rvfi_trace_buf
//   Hardware trace capture beside ibex_top. Each RVFI retirement is packed into a
//   160-bit record, queued in a Depth-entry circular FIFO, and streamed out through
//   a one-record output register in OutW-bit valid/ready beats.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rvfi_*_i               retirement information from the core
//   cfg_en_i               capture enable (draining continues when low)
//   cfg_mode_i             full policy: 0 drop-new, 1 overwrite-oldest, 2 stop-on-full, 3 as 0
//   cfg_trig_en_i/_pc_i    hold off capture until a retirement at cfg_trig_pc_i
//   cfg_clr_i              synchronous flush of all state
//   trace_valid_o/ready_i  beat handshake; trace_data_o is the beat, trace_last_o ends a record
//   fill_o                 FIFO occupancy (output register excluded)
//   drop_cnt_o             saturating count of lost records
//   triggered_o, stopped_o sticky status
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth = 16,
    parameter int unsigned OutW  = 32,
    parameter int unsigned CntW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rvfi_valid_i,
    input  logic [63:0]              rvfi_order_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic [31:0]              rvfi_mem_addr_i,
    input  logic [3:0]               rvfi_mem_rmask_i,
    input  logic [3:0]               rvfi_mem_wmask_i,
    input  logic                     rvfi_mem_is_cap_i,
    input  logic                     rvfi_trap_i,
    input  logic                     rvfi_intr_i,
    input  logic                     cfg_en_i,
    input  logic [1:0]               cfg_mode_i,
    input  logic                     cfg_trig_en_i,
    input  logic [31:0]              cfg_trig_pc_i,
    input  logic                     cfg_clr_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [OutW-1:0]          trace_data_o,
    output logic                     trace_last_o,
    output logic [$clog2(Depth):0]   fill_o,
    output logic [CntW-1:0]          drop_cnt_o,
    output logic                     triggered_o,
    output logic                     stopped_o
);
    localparam int unsigned RecW  = 160;
    localparam int unsigned Beats = RecW / OutW;
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned BW    = (Beats > 1) ? $clog2(Beats) : 1;

    typedef logic [RecW-1:0] rec_t;

    // Only the low 16 bits of the order are recorded.
    logic unused_order;
    assign unused_order = ^rvfi_order_i[63:16];

    rec_t rec;
    assign rec = {rvfi_order_i[15:0], rvfi_intr_i, rvfi_trap_i, rvfi_mem_is_cap_i,
                  rvfi_mem_wmask_i, rvfi_mem_rmask_i, rvfi_rd_addr_i, rvfi_mem_addr_i,
                  rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i};

    rec_t                         mem_q [Depth];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [Beats-1:0][OutW-1:0]   or_q, or_d;
    logic                         or_vld_q, or_vld_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [CntW-1:0]              drop_q, drop_d;
    logic                         trig_q, trig_d, stop_q, stop_d;

    // Pointers carry one extra wrap bit: equal means empty, differing only in the MSB means full.
    logic empty, full, accept, accept_last, pop;
    logic pc_hit, capture, room, do_write, overwrite, drop;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign accept      = or_vld_q & trace_ready_i;
    assign accept_last = accept & (beat_q == BW'(Beats - 1));
    // Refill the output register when empty, or in the same edge its last beat leaves.
    assign pop         = ~empty & (~or_vld_q | accept_last);

    assign pc_hit      = (rvfi_pc_rdata_i == cfg_trig_pc_i);
    assign capture     = rvfi_valid_i & cfg_en_i & ~stop_q & (~cfg_trig_en_i | trig_q | pc_hit);
    // A pop in the same cycle frees a slot before the push is considered.
    assign room        = ~full | pop;
    assign drop        = capture & ~room;
    assign overwrite   = drop & (cfg_mode_i == 2'd1);
    assign do_write    = ~cfg_clr_i & capture & (room | overwrite);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        or_d     = or_q;
        or_vld_d = or_vld_q;
        beat_d   = beat_q;
        drop_d   = drop_q;
        trig_d   = trig_q;
        stop_d   = stop_q;
        if (cfg_clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            or_d     = '0;
            or_vld_d = 1'b0;
            beat_d   = '0;
            drop_d   = '0;
            trig_d   = 1'b0;
            stop_d   = 1'b0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
            // pop and overwrite are mutually exclusive (overwrite needs no room).
            if (pop || overwrite) rd_ptr_d = rd_ptr_q + 1'b1;
            if (drop && (drop_q != {CntW{1'b1}})) drop_d = drop_q + 1'b1;
            if (drop && (cfg_mode_i == 2'd2)) stop_d = 1'b1;
            if (rvfi_valid_i && cfg_trig_en_i && pc_hit) trig_d = 1'b1;
            if (pop) begin
                or_d     = mem_q[rd_ptr_q[AW-1:0]];
                or_vld_d = 1'b1;
                beat_d   = '0;
            end else if (accept_last) begin
                or_vld_d = 1'b0;
                beat_d   = '0;
            end else if (accept) begin
                beat_d   = beat_q + 1'b1;
            end
        end
    end

    // Storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= rec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            or_q     <= '0;
            or_vld_q <= 1'b0;
            beat_q   <= '0;
            drop_q   <= '0;
            trig_q   <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            or_q     <= or_d;
            or_vld_q <= or_vld_d;
            beat_q   <= beat_d;
            drop_q   <= drop_d;
            trig_q   <= trig_d;
            stop_q   <= stop_d;
        end
    end

    assign trace_valid_o = or_vld_q;
    assign trace_data_o  = or_q[beat_q];
    assign trace_last_o  = or_vld_q & (beat_q == BW'(Beats - 1));
    assign fill_o        = wr_ptr_q - rd_ptr_q;
    assign drop_cnt_o    = drop_q;
    assign triggered_o   = trig_q;
    assign stopped_o     = stop_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Bench for ibex_rvfi_trace_buf with Depth=4, OutW=32, CntW=3 (small counter to reach saturation).
// Expected records are queued as retirements are driven; a negedge monitor reassembles beats.
module tb_ibex_rvfi_trace_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_pc = '0, rvfi_insn = '0, rvfi_wdata = '0, rvfi_maddr = '0;
    logic [4:0]  rvfi_rd = '0;
    logic [3:0]  rvfi_rmask = '0, rvfi_wmask = '0;
    logic        rvfi_cap = 1'b0, rvfi_trap = 1'b0, rvfi_intr = 1'b0;
    logic        cfg_en = 1'b1, cfg_trig_en = 1'b0, cfg_clr = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] cfg_trig_pc = '0;
    logic        trace_valid, trace_ready = 1'b0, trace_last;
    logic [31:0] trace_data;
    logic [2:0]  fill;
    logic [2:0]  drop_cnt;
    logic        triggered, stopped;

    ibex_rvfi_trace_buf #(.Depth(4), .OutW(32), .CntW(3)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rvfi_valid_i(rvfi_valid), .rvfi_order_i(rvfi_order), .rvfi_pc_rdata_i(rvfi_pc),
        .rvfi_insn_i(rvfi_insn), .rvfi_rd_addr_i(rvfi_rd), .rvfi_rd_wdata_i(rvfi_wdata),
        .rvfi_mem_addr_i(rvfi_maddr), .rvfi_mem_rmask_i(rvfi_rmask), .rvfi_mem_wmask_i(rvfi_wmask),
        .rvfi_mem_is_cap_i(rvfi_cap), .rvfi_trap_i(rvfi_trap), .rvfi_intr_i(rvfi_intr),
        .cfg_en_i(cfg_en), .cfg_mode_i(cfg_mode), .cfg_trig_en_i(cfg_trig_en),
        .cfg_trig_pc_i(cfg_trig_pc), .cfg_clr_i(cfg_clr),
        .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_data_o(trace_data),
        .trace_last_o(trace_last), .fill_o(fill), .drop_cnt_o(drop_cnt),
        .triggered_o(triggered), .stopped_o(stopped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [159:0] exp_q[$], rcv_q[$];
    int  rcv_beats[$];
    int  first_vld = -1, drive_cyc = 0, stab_err = 0;

    // Monitor: reassemble accepted beats; flag any change while stalled.
    initial begin
        int bidx;
        logic [159:0] acc;
        bit hold;
        logic [31:0] hold_data;
        logic hold_last;
        bidx = 0; acc = '0; hold = 0; hold_data = '0; hold_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || cfg_clr) begin
                bidx = 0; hold = 0;
            end else begin
                if (hold && (!trace_valid || trace_data !== hold_data || trace_last !== hold_last))
                    stab_err++;
                hold = trace_valid && !trace_ready;
                hold_data = trace_data;
                hold_last = trace_last;
                if (trace_valid && first_vld < 0) first_vld = cyc;
                if (trace_valid && trace_ready && bidx < 5) begin
                    acc[bidx*32 +: 32] = trace_data;
                    bidx++;
                    if (trace_last) begin
                        rcv_q.push_back(acc);
                        rcv_beats.push_back(bidx);
                        bidx = 0;
                    end
                end
            end
        end
    end

    function automatic logic [159:0] pack(input logic [15:0] ord, input logic [31:0] pc,
                                          input logic [31:0] insn);
        return {ord, ord[2], ord[1], ord[0], ~ord[3:0], ord[3:0], ord[4:0] ^ 5'h15,
                pc ^ 32'h5a5a_0000, {ord, ~ord}, insn, pc};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic retire(input logic [15:0] ord, input logic [31:0] pc, input logic [31:0] insn,
                          input bit exp);
        logic [159:0] r;
        r = pack(ord, pc, insn);
        rvfi_valid = 1'b1;
        rvfi_order = {48'ha5a5_a5a5_a5a5, ord};
        {rvfi_pc, rvfi_insn, rvfi_wdata, rvfi_maddr} = {r[31:0], r[63:32], r[95:64], r[127:96]};
        {rvfi_rd, rvfi_rmask, rvfi_wmask} = {r[132:128], r[136:133], r[140:137]};
        {rvfi_cap, rvfi_trap, rvfi_intr} = {r[141], r[142], r[143]};
        if (exp) exp_q.push_back(r);
        drive_cyc = cyc;
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic wait_rcv(input int n, output bit ok);
        int b = 0;
        while (rcv_q.size() < n && b < 500) begin tick(); b++; end
        ok = (rcv_q.size() >= n);
    endtask

    task automatic do_clr();
        cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
        exp_q.delete(); rcv_q.delete(); rcv_beats.delete();
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({trace_valid, trace_data, trace_last, fill, drop_cnt, triggered, stopped} !== '0) begin
            n_fail++; $display("FAIL reset_in got v%b d%h f%0d dc%0d", trace_valid, trace_data, fill, drop_cnt);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if ({trace_valid, trace_data, trace_last, fill, drop_cnt, triggered, stopped} !== '0) begin
            n_fail++; $display("FAIL reset_out got v%b d%h f%0d dc%0d", trace_valid, trace_data, fill, drop_cnt);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [159:0] g, e;
        trace_ready = 1'b1; first_vld = -1;
        retire(16'h0, 32'h8000_0000, 32'h0000_0013, 1);
        wait_rcv(1, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout got 0 records want 1"); end
        else begin
            n_chk++;
            if (first_vld !== drive_cyc + 2) begin
                n_fail++; $display("FAIL single_latency got %0d want %0d", first_vld - drive_cyc, 2);
            end
            g = rcv_q.pop_front(); e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL single_rec got %h want %h", g, e); end
            n_chk++;
            if (g[31:0] !== 32'h8000_0000) begin n_fail++; $display("FAIL single_beat0 got %h want 80000000", g[31:0]); end
            n_chk++;
            if (g[63:32] !== 32'h13) begin n_fail++; $display("FAIL single_beat1 got %h want 00000013", g[63:32]); end
            n_chk++;
            if (rcv_beats[0] !== 5) begin n_fail++; $display("FAIL single_last got beat %0d want 5", rcv_beats[0]); end
        end
    endtask

    task automatic test_drop_new();
        bit ok;
        logic [159:0] g, e;
        do_clr(); cfg_mode = 2'd0; trace_ready = 1'b0;
        for (int o = 1; o <= 7; o++) retire(16'(o), 32'h1000 + 32'(o * 4), 32'h13 | 32'(o << 7), o <= 5);
        tick();
        n_chk++;
        if (fill !== 3'd4) begin n_fail++; $display("FAIL dropnew_fill got %0d want 4", fill); end
        n_chk++;
        if (drop_cnt !== 3'd2) begin n_fail++; $display("FAIL dropnew_cnt got %0d want 2", drop_cnt); end
        n_chk++;
        if (!trace_valid || trace_data !== 32'h1004) begin
            n_fail++; $display("FAIL dropnew_or got v%b %h want v1 00001004", trace_valid, trace_data);
        end
        trace_ready = 1'b1;
        wait_rcv(5, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL dropnew_rec got %h want %h", g, e); end
        end
        n_chk++;
        if (fill !== 3'd0) begin n_fail++; $display("FAIL dropnew_empty got %0d want 0", fill); end
    endtask

    task automatic test_overwrite();
        bit ok;
        logic [159:0] g, e;
        do_clr(); cfg_mode = 2'd1; trace_ready = 1'b0;
        for (int o = 1; o <= 7; o++) retire(16'(o), 32'h2000 + 32'(o * 4), 32'h33 | 32'(o << 7), o == 1 || o >= 4);
        tick();
        n_chk++;
        if (drop_cnt !== 3'd2 || fill !== 3'd4) begin
            n_fail++; $display("FAIL overwrite_status got dc%0d f%0d want dc2 f4", drop_cnt, fill);
        end
        trace_ready = 1'b1;
        wait_rcv(5, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL overwrite_rec got %h want %h", g, e); end
        end
    endtask

    task automatic test_stop();
        bit ok;
        logic [159:0] g, e;
        do_clr(); cfg_mode = 2'd2; trace_ready = 1'b0;
        for (int o = 1; o <= 6; o++) retire(16'(o), 32'h3000 + 32'(o * 4), 32'h13, o <= 5);
        tick();
        n_chk++;
        if (stopped !== 1'b1 || drop_cnt !== 3'd1) begin
            n_fail++; $display("FAIL stop_status got s%b dc%0d want s1 dc1", stopped, drop_cnt);
        end
        trace_ready = 1'b1;
        for (int o = 8; o <= 10; o++) retire(16'(o), 32'h3000 + 32'(o * 4), 32'h13, 0);
        wait_rcv(5, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL stop_rec got %h want %h", g, e); end
        end
        repeat (6) tick();
        n_chk++;
        if (rcv_q.size() != 0 || trace_valid !== 1'b0 || fill !== 3'd0 || drop_cnt !== 3'd1) begin
            n_fail++; $display("FAIL stop_nocapture got extra=%0d v%b f%0d dc%0d want 0 0 0 1",
                               rcv_q.size(), trace_valid, fill, drop_cnt);
        end
        do_clr(); cfg_mode = 2'd0;
        n_chk++;
        if ({fill, drop_cnt, triggered, stopped, trace_valid} !== '0) begin
            n_fail++; $display("FAIL stop_clr got f%0d dc%0d t%b s%b v%b want all 0",
                               fill, drop_cnt, triggered, stopped, trace_valid);
        end
    endtask

    task automatic test_trigger();
        bit ok;
        logic [159:0] g, e;
        do_clr(); cfg_trig_en = 1'b1; cfg_trig_pc = 32'h100; trace_ready = 1'b1;
        retire(16'd1, 32'hF8, 32'h13, 0);
        retire(16'd2, 32'hFC, 32'h13, 0);
        n_chk++;
        if (triggered !== 1'b0) begin n_fail++; $display("FAIL trig_early got %b want 0", triggered); end
        retire(16'd3, 32'h100, 32'h13, 1);
        retire(16'd4, 32'h104, 32'h13, 1);
        n_chk++;
        if (triggered !== 1'b1) begin n_fail++; $display("FAIL trig_set got %b want 1", triggered); end
        wait_rcv(2, ok);
        repeat (4) tick();
        n_chk++;
        if (rcv_q.size() != 2) begin n_fail++; $display("FAIL trig_count got %0d want 2", rcv_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL trig_rec got %h want %h", g, e); end
        end
        cfg_trig_en = 1'b0;
        do_clr();
    endtask

    task automatic test_full_pop();
        bit ok;
        int b;
        logic [159:0] g, e;
        do_clr(); cfg_mode = 2'd0; trace_ready = 1'b0; stab_err = 0;
        for (int o = 1; o <= 5; o++) retire(16'(o), 32'h4000 + 32'(o * 4), 32'h13, 1);
        tick();
        n_chk++;
        if (fill !== 3'd4) begin n_fail++; $display("FAIL fullpop_prefill got %0d want 4", fill); end
        trace_ready = 1'b1;
        repeat (4) tick();
        // last beat of record 1 leaves on the same edge record 6 arrives
        retire(16'd6, 32'h4018, 32'h13, 1);
        trace_ready = 1'b0;
        n_chk++;
        if (fill !== 3'd4 || drop_cnt !== 3'd0) begin
            n_fail++; $display("FAIL fullpop_nodrop got f%0d dc%0d want f4 dc0", fill, drop_cnt);
        end
        n_chk++;
        if (trace_valid !== 1'b1 || trace_data !== 32'h4008) begin
            n_fail++; $display("FAIL fullpop_refill got v%b %h want v1 00004008", trace_valid, trace_data);
        end
        b = 0;
        while (rcv_q.size() < 6 && b < 2000) begin
            trace_ready = 1'($urandom_range(0, 1)); tick(); b++;
        end
        trace_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL fullpop_rec got %h want %h", g, e); end
        end
        n_chk++;
        if (stab_err != 0) begin n_fail++; $display("FAIL beat_stable got %0d violations want 0", stab_err); end
    endtask

    task automatic test_saturate();
        bit ok;
        logic [159:0] g, e;
        do_clr(); trace_ready = 1'b0;
        for (int o = 1; o <= 15; o++) retire(16'(o), 32'h5000 + 32'(o * 4), 32'h13, o <= 5);
        tick();
        n_chk++;
        if (drop_cnt !== 3'd7) begin n_fail++; $display("FAIL saturate got %0d want 7", drop_cnt); end
        trace_ready = 1'b1;
        wait_rcv(5, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL saturate_rec got %h want %h", g, e); end
        end
    endtask

    task automatic test_enable();
        bit ok;
        logic [159:0] g, e;
        do_clr(); trace_ready = 1'b0;
        retire(16'd1, 32'h6004, 32'h13, 1);
        cfg_en = 1'b0;
        retire(16'd2, 32'h6008, 32'h13, 0);
        retire(16'd3, 32'h600C, 32'h13, 0);
        tick();
        n_chk++;
        if (fill !== 3'd0 || drop_cnt !== 3'd0) begin
            n_fail++; $display("FAIL enable_nocapture got f%0d dc%0d want 0 0", fill, drop_cnt);
        end
        trace_ready = 1'b1;
        wait_rcv(1, ok);
        repeat (6) tick();
        n_chk++;
        if (rcv_q.size() != 1) begin n_fail++; $display("FAIL enable_drain got %0d want 1", rcv_q.size()); end
        e = exp_q.pop_front();
        g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL enable_rec got %h want %h", g, e); end
        cfg_en = 1'b1;
    endtask

    task automatic test_clr_same_cycle();
        do_clr(); trace_ready = 1'b0;
        retire(16'd1, 32'h7004, 32'h13, 0);
        retire(16'd2, 32'h7008, 32'h13, 0);
        tick();
        cfg_clr = 1'b1;
        retire(16'd3, 32'h700C, 32'h13, 0);
        cfg_clr = 1'b0;
        n_chk++;
        if (trace_valid !== 1'b0 || fill !== 3'd0) begin
            n_fail++; $display("FAIL clr_same got v%b f%0d want v0 f0", trace_valid, fill);
        end
        trace_ready = 1'b1;
        repeat (8) tick();
        n_chk++;
        if (rcv_q.size() != 0) begin n_fail++; $display("FAIL clr_discard got %0d records want 0", rcv_q.size()); end
    endtask

    task automatic test_midreset();
        bit ok;
        logic [159:0] g, e;
        do_clr(); trace_ready = 1'b0;
        for (int o = 1; o <= 3; o++) retire(16'(o), 32'h8004 + 32'(o * 4), 32'h13, 0);
        trace_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({trace_valid, trace_data, trace_last, fill, drop_cnt, triggered, stopped} !== '0) begin
            n_fail++; $display("FAIL midreset got v%b d%h f%0d", trace_valid, trace_data, fill);
        end
        tick();
        rst_n = 1'b1;
        exp_q.delete(); rcv_q.delete(); rcv_beats.delete();
        tick();
        retire(16'd9, 32'h9000, 32'h13, 1);
        wait_rcv(1, ok);
        e = exp_q.pop_front();
        g = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL midreset_recover got %h want %h", g, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop_new();
        test_overwrite();
        test_stop();
        test_trigger();
        test_full_pop();
        test_saturate();
        test_enable();
        test_clr_same_cycle();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
